// File: rtl/controller_sra_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_sra_if
// Description : Start/Done handshake, captured operation fields and the
//               datapath control lines of the SRA sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface controller_sra_if #(
    parameter int ITER_W = 3
) ();
    // System-facing request and operation fields
    logic              Start;
    logic [1:0]        Au1Op;
    logic [1:0]        Au2Op;
    logic              OpSel;
    logic              ResSel;
    logic              WbSel;
    logic [ITER_W-1:0] Iter;
    // Datapath control lines
    logic              In;
    logic [1:0]        Bus2;
    logic              AU1_Bus3;
    logic              AU1_Bus4;
    logic [1:0]        Bus5;
    logic [1:0]        Bus7;
    logic [4:0]        LR;
    logic [3:0]        Opcode;
    logic              Done;
    logic              Busy;

    // Requester side: drives the request, observes the control word
    modport master (
        output Start, Au1Op, Au2Op, OpSel, ResSel, WbSel, Iter,
        input  In, Bus2, AU1_Bus3, AU1_Bus4, Bus5, Bus7, LR, Opcode, Done, Busy
    );

    // Controller side
    modport slave (
        input  Start, Au1Op, Au2Op, OpSel, ResSel, WbSel, Iter,
        output In, Bus2, AU1_Bus3, AU1_Bus4, Bus5, Bus7, LR, Opcode, Done, Busy
    );
endinterface
`default_nettype wire

// File: rtl/controller_sra.sv
`default_nettype none
// ============================================================================
// Module      : controller_sra
// Description : Moore control FSM for the SRA datapath. Sequences
//               load -> AU1 (with optional writeback iterations) -> AU2 ->
//               result, behind a level Start/Done handshake.
// Revision    : 1.0  initial release
// ============================================================================
module controller_sra #(
    parameter int ITER_W = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    controller_sra_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXEC1  = 3'd2,
        S_LATCH1 = 3'd3,
        S_WB     = 3'd4,
        S_EXEC2  = 3'd5,
        S_LATCH2 = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t            state_q,  state_d;
    logic [ITER_W-1:0] cnt_q,    cnt_d;
    logic [1:0]        au1op_q,  au1op_d;
    logic [1:0]        au2op_q,  au2op_d;
    logic              opsel_q,  opsel_d;
    logic              ressel_q, ressel_d;
    logic              wbsel_q,  wbsel_d;

    logic              w_in;
    logic [1:0]        w_bus2;
    logic              w_au1_bus3;
    logic              w_au1_bus4;
    logic [1:0]        w_bus5;
    logic [1:0]        w_bus7;
    logic [4:0]        w_lr;
    logic [3:0]        w_opcode;
    logic              w_done;
    logic              w_busy;

    // State, iteration counter and captured operation fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            au1op_q  <= '0;
            au2op_q  <= '0;
            opsel_q  <= 1'b0;
            ressel_q <= 1'b0;
            wbsel_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            au1op_q  <= au1op_d;
            au2op_q  <= au2op_d;
            opsel_q  <= opsel_d;
            ressel_q <= ressel_d;
            wbsel_q  <= wbsel_d;
        end
    end

    // Next-state logic; fields are captured only when leaving IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        au1op_d  = au1op_q;
        au2op_d  = au2op_q;
        opsel_d  = opsel_q;
        ressel_d = ressel_q;
        wbsel_d  = wbsel_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    au1op_d  = bus.Au1Op;
                    au2op_d  = bus.Au2Op;
                    opsel_d  = bus.OpSel;
                    ressel_d = bus.ResSel;
                    wbsel_d  = bus.WbSel;
                    cnt_d    = bus.Iter;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD:   state_d = S_EXEC1;
            S_EXEC1:  state_d = S_LATCH1;
            S_LATCH1: state_d = (cnt_q != '0) ? S_WB : S_EXEC2;
            S_WB: begin
                // WB is only entered with a non-zero count; the guard keeps
                // the counter from ever wrapping regardless.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ITER_W'(1);
                end
                state_d = S_EXEC1;
            end
            S_EXEC2:  state_d = S_LATCH2;
            S_LATCH2: state_d = S_DONE;
            S_DONE:   state_d = bus.Start ? S_DONE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control word decoded purely from registered state
    always_comb begin
        w_in       = 1'b0;
        w_bus2     = 2'b00;
        w_au1_bus3 = 1'b0;
        w_au1_bus4 = 1'b0;
        w_bus5     = 2'b00;
        w_bus7     = 2'b00;
        w_lr       = 5'b00000;
        w_done     = 1'b0;
        w_busy     = (state_q != S_IDLE);
        w_opcode   = (state_q != S_IDLE) ? {au2op_q, au1op_q} : 4'b0000;
        case (state_q)
            S_LOAD: begin
                w_in = 1'b1;
                w_lr = 5'b00011;
            end
            S_EXEC1: begin
                w_bus2 = opsel_q ? 2'b10 : 2'b01;
            end
            S_LATCH1: begin
                w_bus2 = opsel_q ? 2'b10 : 2'b01;
                w_bus7 = 2'b01;
                w_lr   = 5'b11100;
            end
            S_WB: begin
                w_bus2     = opsel_q ? 2'b10 : 2'b01;
                w_au1_bus3 = ~wbsel_q;
                w_au1_bus4 = wbsel_q;
                w_lr       = wbsel_q ? 5'b00010 : 5'b00001;
            end
            S_EXEC2: begin
                w_bus5 = ressel_q ? 2'b10 : 2'b01;
            end
            S_LATCH2: begin
                w_bus5 = ressel_q ? 2'b10 : 2'b01;
                w_bus7 = 2'b10;
                w_lr   = 5'b00100;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_in = 1'b0;
            end
        endcase
    end

    assign bus.In       = w_in;
    assign bus.Bus2     = w_bus2;
    assign bus.AU1_Bus3 = w_au1_bus3;
    assign bus.AU1_Bus4 = w_au1_bus4;
    assign bus.Bus5     = w_bus5;
    assign bus.Bus7     = w_bus7;
    assign bus.LR       = w_lr;
    assign bus.Opcode   = w_opcode;
    assign bus.Done     = w_done;
    assign bus.Busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_controller_sra.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_sra
// Description : Scoreboard bench for controller_sra. The stimulus thread
//               pushes the hand-derived control word expected for every
//               cycle; a monitor pops and compares on each falling edge and
//               also checks the bus-exclusivity rules every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_controller_sra;

    localparam int ITER_W = 3;

    logic clk;
    logic rst_n;

    controller_sra_if #(.ITER_W(ITER_W)) intf ();

    controller_sra #(.ITER_W(ITER_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    logic [19:0] exp_q[$];
    string       name_q[$];
    int          n_vec;
    int          n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word packing: {In,Bus2,B3,B4,Bus5,Bus7,LR,Opcode,Done,Busy}
    function automatic logic [19:0] mk(input logic in_, input logic [1:0] b2,
                                       input logic b3, input logic b4,
                                       input logic [1:0] b5, input logic [1:0] b7,
                                       input logic [4:0] lr, input logic [3:0] op,
                                       input logic dn, input logic bz);
        return {in_, b2, b3, b4, b5, b7, lr, op, dn, bz};
    endfunction

    localparam logic [19:0] ZERO = 20'd0;

    // Advance one cycle and queue the word expected after this edge
    task automatic step(input logic [19:0] e, input string nm);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_op(input logic [1:0] au1, input logic [1:0] au2,
                          input logic opsel, input logic ressel, input logic wbsel,
                          input int iter, input logic hold);
        logic [3:0] op;
        logic [1:0] b2;
        logic [1:0] b5;
        op = {au2, au1};
        b2 = opsel  ? 2'b10 : 2'b01;
        b5 = ressel ? 2'b10 : 2'b01;
        intf.Au1Op  = au1;
        intf.Au2Op  = au2;
        intf.OpSel  = opsel;
        intf.ResSel = ressel;
        intf.WbSel  = wbsel;
        intf.Iter   = ITER_W'(iter);
        intf.Start  = 1'b1;
        step(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00011, op, 1'b0, 1'b1), "load");
        if (!hold) intf.Start = 1'b0;
        for (int k = 0; k <= iter; k++) begin
            step(mk(1'b0, b2, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, op, 1'b0, 1'b1), "exec1");
            if (!hold && k == 0) begin
                intf.Au1Op  = ~au1;
                intf.Au2Op  = ~au2;
                intf.OpSel  = ~opsel;
                intf.ResSel = ~ressel;
                intf.WbSel  = ~wbsel;
                intf.Iter   = 3'd5;
            end
            step(mk(1'b0, b2, 1'b0, 1'b0, 2'b00, 2'b01, 5'b11100, op, 1'b0, 1'b1), "latch1");
            if (k < iter) begin
                step(mk(1'b0, b2, ~wbsel, wbsel, 2'b00, 2'b00,
                        wbsel ? 5'b00010 : 5'b00001, op, 1'b0, 1'b1), "wb");
            end
        end
        step(mk(1'b0, 2'b00, 1'b0, 1'b0, b5, 2'b00, 5'b00000, op, 1'b0, 1'b1), "exec2");
        step(mk(1'b0, 2'b00, 1'b0, 1'b0, b5, 2'b10, 5'b00100, op, 1'b0, 1'b1), "latch2");
        step(mk(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, op, 1'b1, 1'b1), "done");
        if (hold) begin
            step(mk(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, op, 1'b1, 1'b1), "done_hold");
            step(mk(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, op, 1'b1, 1'b1), "done_hold");
            intf.Start = 1'b0;
        end
        step(ZERO, "idle_after");
    endtask

    // Monitor: invariants every cycle, scoreboard compare when a word is due
    initial begin
        logic [19:0] act;
        logic [19:0] e;
        string       nm;
        n_vec = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            act = {intf.In, intf.Bus2, intf.AU1_Bus3, intf.AU1_Bus4, intf.Bus5,
                   intf.Bus7, intf.LR, intf.Opcode, intf.Done, intf.Busy};
            n_vec++;
            if (!($onehot0(intf.Bus2) && $onehot0(intf.Bus5) && $onehot0(intf.Bus7) &&
                  $onehot0({intf.In, intf.AU1_Bus3, intf.AU1_Bus4}) &&
                  !(intf.LR[0] && intf.AU1_Bus4) && !(intf.LR[1] && intf.AU1_Bus3))) begin
                n_bad++;
                $display("FAIL exclusivity t=%0t word=%b", $time, act);
            end
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, e);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        intf.Start  = 1'b0;
        intf.Au1Op  = 2'b00;
        intf.Au2Op  = 2'b00;
        intf.OpSel  = 1'b0;
        intf.ResSel = 1'b0;
        intf.WbSel  = 1'b0;
        intf.Iter   = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset and idle
        step(ZERO, "reset");
        step(ZERO, "reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(ZERO, "idle");

        // Basic op with Start held through DONE
        run_op(2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        // Iterations with writeback to R2, then to R1
        run_op(2'd1, 2'd3, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        run_op(2'd3, 2'd2, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        // Maximum iteration count
        run_op(2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 7, 1'b0);

        // Async reset asserted between edges while in WB
        intf.Au1Op  = 2'd1;
        intf.Au2Op  = 2'd1;
        intf.OpSel  = 1'b0;
        intf.ResSel = 1'b0;
        intf.WbSel  = 1'b1;
        intf.Iter   = 3'd3;
        intf.Start  = 1'b1;
        step(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00011, 4'b0101, 1'b0, 1'b1), "rst_load");
        step(mk(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 4'b0101, 1'b0, 1'b1), "rst_exec1");
        step(mk(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 5'b11100, 4'b0101, 1'b0, 1'b1), "rst_latch1");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        intf.Start = 1'b0;
        #1;
        exp_q.push_back(ZERO);
        name_q.push_back("async_reset");
        @(posedge clk);
        #1;
        step(ZERO, "in_reset");
        rst_n = 1'b1;
        step(ZERO, "post_reset");
        step(ZERO, "post_reset");
        run_op(2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0);

        // One-cycle Start pulse, fields scrambled after capture
        run_op(2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(ZERO, "idle_end");

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controller_sra.md
Name: controller_sra

Overview:
Control FSM sitting directly upstream of the SRA datapath. It drives all of the datapath's control lines:
- tri-state bus enables
- register load strobes LR
- AU opcodes
- Done

It sequences load -> AU1 (optionally iterated with writeback) -> AU2 -> result. A simple level Start/Done handshake faces the system.

Parameters:
ITER_W, 3, width of iteration-count field and internal down-counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  level request; sampled in IDLE
Au1Op  input  2  AU1 operation code, captured at start
Au2Op  input  2  AU2 operation code, captured at start
OpSel  input  1  AU1 second operand: 0=R1, 1=R2
ResSel  input  1  AU2 first operand: 0=R4 (AU1 result), 1=R5 (shifted R1)
WbSel  input  1  writeback target: 0=R1 via AU1_Bus3, 1=R2 via AU1_Bus4
Iter  input  ITER_W  number of AU1 writeback iterations (0..7)
In  output  1  drive Input1/Input2 onto E/F buses
Bus2  output  2  B2 bus select, one-hot: 01=R1, 10=R2
AU1_Bus3  output  1  drive AU1 onto E bus
AU1_Bus4  output  1  drive AU1 onto F bus
Bus5  output  2  B5 select, one-hot: 01=R4, 10=R5
Bus7  output  2  B7 select, one-hot: 01=Sh3, 10=AU2
LR  output  5  load strobes: bit0 R1, bit1 R2, bit2 R3, bit3 R4, bit4 R5
Opcode  output  4  {Au2Op, Au1Op}
Done  output  1  result valid / Result tri-state enable
Busy  output  1  high in every state except IDLE

Behaviour:
- Moore FSM: all outputs decode from the state register only. Control words below list only the asserted signals; every unlisted signal is 0.
- Reset (async, rst_n=0): state=IDLE, counter=0, captured fields=0, all outputs 0. Reset mid-operation aborts immediately with no completion.
- IDLE: all outputs 0.
  - On Start=1 at a clk edge: capture Au1Op, Au2Op, OpSel, ResSel, WbSel, Iter; counter<=Iter; go to LOAD.
- LOAD: In=1, LR=00011. -> EXEC1.
- EXEC1: Bus2 = OpSel?10:01. -> LATCH1.
  - Gives AU1 (registered) one cycle.
- LATCH1: Bus2 held, Bus7=01, LR=11100 (R3<=Sh3, R4<=AU1, R5<=Sh1).
  - counter!=0 -> WB.
  - counter==0 -> EXEC2.
- WB: Bus2 held, counter decrements.
  - WbSel=0: AU1_Bus3=1, LR=00001.
  - WbSel=1: AU1_Bus4=1, LR=00010.
  - -> EXEC1.
- EXEC2: Bus5 = ResSel?10:01. -> LATCH2.
  - Gives AU2 (registered) one cycle.
- LATCH2: Bus5 held, Bus7=10, LR=00100 (R3<=AU2). -> DONE.
- DONE: Done=1.
  - Start=1: stay in DONE.
  - Start=0: -> IDLE.
  - If Start is already low on entry, Done is exactly 1 cycle.
- Opcode = captured {Au2Op,Au1Op} in all non-IDLE states; 0 in IDLE.
- Bus exclusivity invariants, checked every cycle:
  - Bus2, Bus5 and Bus7 are each zero or one-hot.
  - In, AU1_Bus3 and AU1_Bus4 are pairwise mutually exclusive.
  - LR[0] is never high with AU1_Bus4; LR[1] is never high with AU1_Bus3.
- Start deasserted mid-operation is ignored; the sequence runs to DONE.
- Input fields changing after capture have no effect.
- Latency, counting the capture edge as cycle 0: Done first high at cycle 6+3*Iter. Iter=7 gives cycle 27.
- Counter: ITER_W-bit down-counter, decremented only in WB, never wraps. The FSM exits to EXEC2 when it reaches 0.
- Illegal or unreachable state encodings -> IDLE on the next edge.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then release with Start=0 -> all outputs 0, Busy=0, for 10 cycles.
- Basic op: Start=1 held, Iter=0, Au1Op=2, Au2Op=1, OpSel=1, ResSel=0.
  - Cycle 1: In=1, LR=00011.
  - Cycle 2: Bus2=10.
  - Cycle 3: LR=11100, Bus7=01.
  - Cycle 4: Bus5=01.
  - Cycle 5: Bus7=10, LR=00100.
  - Cycle 6: Done=1 and held while Start=1, with Opcode=0110 throughout.
  - Start=0 -> IDLE next cycle.
- Iteration: Iter=3, WbSel=1 -> exactly 3 WB cycles, each with AU1_Bus4=1, LR=00010; Done at cycle 15. Repeat with WbSel=0 -> AU1_Bus3=1, LR=00001.
- Max count: Iter=7 -> Done at cycle 27, no counter wrap, exactly 7 WB visits.
- Async reset mid-op: assert rst_n=0 during WB (between edges) -> outputs 0 immediately; after release, state is IDLE and a new Start runs cleanly.
- Handshake edge: Start pulsed 1 cycle with Iter=0 and field inputs changed at cycle 2 -> completes with captured values; Done high exactly 1 cycle at cycle 6. Bus one-hot/exclusivity assertions hold in all tests.
